// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads instruction memory over mem_rd/mem_ready,
// and presents instructions with a valid/ack handshake. Optional macro: IFETCH_BOUNDS_EN.
module instr_fetch #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RESET_PC    = 0,
  parameter int MEM_TIMEOUT = 15,
  parameter int PC_LIMIT    = 16'hF000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              instr_ack,
  input  logic              halt,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FAULT} state_t;

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [7:0]        TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [1:0]        CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0]        CAUSE_BOUNDS  = 2'b10;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic [DATA_W-1:0] r_instruction;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_fault;
  logic [1:0]        r_fault_cause;

  logic w_start;
  logic w_oob;

  assign w_start = fetch_req && !halt;

`ifdef IFETCH_BOUNDS_EN
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PC_LIMIT);
  assign w_oob = (r_pc >= LIMIT);
`else
  assign w_oob = 1'b0;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // The asynchronous reset also drops mem_rd at once, abandoning any read in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_pc          <= PC_RST;
      r_mem_addr    <= PC_RST;
      r_mem_rd      <= 1'b0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
    end else begin
      if (pc_load) r_pc <= pc_load_value;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_oob) begin
              r_fault       <= 1'b1;
              r_fault_cause <= CAUSE_BOUNDS;
              r_state       <= S_FAULT;
            end else begin
              r_mem_addr <= r_pc;
              r_mem_rd   <= 1'b1;
              r_cnt      <= '0;
              r_state    <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (mem_ready) begin
            r_instruction <= mem_rdata;
            r_instr_pc    <= r_mem_addr;
            r_instr_valid <= 1'b1;
            r_mem_rd      <= 1'b0;
            r_state       <= S_HOLD;
            // A branch landing on the same edge overrides the sequential increment.
            if (!pc_load) r_pc <= r_pc + ADDR_W'(1);
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt + 8'd1 == TIMEOUT) begin
              r_mem_rd      <= 1'b0;
              r_fault       <= 1'b1;
              r_fault_cause <= CAUSE_TIMEOUT;
              r_state       <= S_FAULT;
            end
          end
        end

        S_HOLD: begin
          if (instr_ack) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_mem_rd      <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign instr_pc    = r_instr_pc;
  assign pc          = r_pc;
  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;

endmodule
